prime_check: RTL and testbench

PRIME_CHECK -- requirements
Module: prime_check

---
 rtl/prime_check_pkg.sv | 20 ++
 rtl/prime_check_divmod.sv | 80 ++++++++
 rtl/prime_check.sv | 133 +++++++++++++
 tb/tb_prime_check.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/prime_check_pkg.sv
// Shared definitions for the prime_check block: operand-width helpers and FSM encoding.
package prime_check_pkg;

  localparam int unsigned PC_WIDTH_LOG = 4;

  function automatic int unsigned pc_width(input int unsigned width_log);
    return 32'd1 << width_log;
  endfunction

  localparam int unsigned PC_W  = pc_width(PC_WIDTH_LOG);
  localparam int unsigned PC_W2 = 2 * PC_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIV,
    ST_DONE
  } state_e;

endpackage

// File: rtl/prime_check_divmod.sv
// W-bit restoring divider producing only the remainder; done pulses exactly W cycles
// after start (the first bit is processed on the start edge itself).
module prime_check_divmod
  import prime_check_pkg::*;
#(
  parameter int unsigned WIDTH_LOG = PC_WIDTH_LOG,
  localparam int unsigned W = pc_width(WIDTH_LOG)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] rem
);

  localparam int unsigned CW = (WIDTH_LOG < 1) ? 1 : WIDTH_LOG;

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  function automatic logic [W-1:0] rstep(input logic [W-1:0] r, input logic b,
                                         input logic [W-1:0] dv);
    logic [W:0] t;
    t = {r, b};
    if (t >= {1'b0, dv}) t = t - {1'b0, dv};
    return t[W-1:0];
  endfunction

  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = rstep('0, dividend[W-1], divisor);
      dvd_d  = {dividend[W-2:0], 1'b0};
      dsr_d  = divisor;
      cnt_d  = CW'(W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rstep(rem_q, dvd_q[W-1], dsr_q);
      dvd_d = {dvd_q[W-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign rem  = rem_q;

endmodule

// File: rtl/prime_check.sv
// Trial-division primality tester: finds the smallest factor >1 of n by dividing by 2
// and then odd d while d*d <= n.
module prime_check
  import prime_check_pkg::*;
#(
  parameter int unsigned WIDTH_LOG = PC_WIDTH_LOG,
  localparam int unsigned W = pc_width(WIDTH_LOG),
  localparam int unsigned W2 = 2 * W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic [W-1:0] n,
  output logic         ready,
  output logic         error,
  output logic         is_prime,
  output logic [W-1:0] res
);

  state_e        state_q, state_d;
  logic [W-1:0]  n_q, n_d;
  logic [W:0]    d_q, d_d;
  logic [W2-1:0] dsq_q, dsq_d;
  logic          hit_q, hit_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;
  logic          prime_q, prime_d;
  logic [W-1:0]  res_q, res_d;

  logic          div_start;
  logic          div_done;
  logic [W-1:0]  div_rem;
  logic          n_small;

  assign n_small = (n_q < W'(2));

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    dsq_d     = dsq_q;
    hit_d     = hit_q;
    ready_d   = ready_q;
    error_d   = error_q;
    prime_d   = prime_q;
    res_d     = res_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          n_d     = n;
          d_d     = (W+1)'(2);
          dsq_d   = W2'(4);
          hit_d   = 1'b0;
          ready_d = 1'b0;
          state_d = ST_CHECK;
        end
      end
      // A divisor found in DIV is routed back through CHECK so that every test
      // loop (hit or miss) costs the same W+1 cycles.
      ST_CHECK: begin
        if (n_small || hit_q || (dsq_q > W2'(n_q))) begin
          state_d = ST_DONE;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          if (div_rem == '0) begin
            hit_d = 1'b1;
          end else if (d_q == (W+1)'(2)) begin
            d_d   = (W+1)'(3);
            dsq_d = W2'(9);
          end else begin
            d_d   = d_q + (W+1)'(2);
            dsq_d = dsq_q + W2'({d_q, 2'b00}) + W2'(4);
          end
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        error_d = n_small;
        prime_d = !n_small && !hit_q;
        res_d   = n_small ? '0 : (hit_q ? d_q[W-1:0] : n_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      d_q     <= (W+1)'(2);
      dsq_q   <= W2'(4);
      hit_q   <= 1'b0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      prime_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      dsq_q   <= dsq_d;
      hit_q   <= hit_d;
      ready_q <= ready_d;
      error_q <= error_d;
      prime_q <= prime_d;
      res_q   <= res_d;
    end
  end

  prime_check_divmod #(.WIDTH_LOG(WIDTH_LOG)) u_divmod (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (n_q),
    .divisor  (d_q[W-1:0]),
    .done     (div_done),
    .rem      (div_rem)
  );

  assign ready    = ready_q;
  assign error    = error_q;
  assign is_prime = prime_q;
  assign res      = res_q;

endmodule

// File: tb/tb_prime_check.sv
// Self-checking bench for prime_check (WIDTH_LOG=4) against a plain-arithmetic factor model.
module tb_prime_check;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         go = 1'b0;
  logic [W-1:0] n = '0;
  logic         ready, error, is_prime;
  logic [W-1:0] res;

  int checks = 0;
  int errors = 0;

  prime_check #(.WIDTH_LOG(4)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .n(n),
    .ready(ready), .error(error), .is_prime(is_prime), .res(res)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Smallest factor >1 found by trying 2 then odd numbers up to sqrt(n); k = divisors tried.
  function automatic void model(input int unsigned nv, output bit e, output bit p,
                                output int unsigned r, output int k);
    e = 0; p = 0; r = 0; k = 0;
    if (nv < 2) begin
      e = 1;
      return;
    end
    for (int unsigned t = 2; t * t <= nv; t = (t == 2) ? 3 : t + 2) begin
      k++;
      if (nv % t == 0) begin
        r = t;
        return;
      end
    end
    p = 1;
    r = nv;
  endfunction

  // Drives one request and waits for ready; spur = loop index at which a busy go(13) is pulsed.
  task automatic issue(input logic [W-1:0] nv, input int spur, input bit armed,
                       output int lat, output bit moved);
    logic pe, pp;
    logic [W-1:0] pr;
    if (!armed) begin
      @(negedge clk);
      go = 1'b1;
      n  = nv;
    end
    pe = error; pp = is_prime; pr = res;
    @(posedge clk); #1;
    go = 1'b0;
    lat = 0;
    moved = 0;
    while (lat < 4000) begin
      if (lat == spur) begin
        @(negedge clk);
        go = 1'b1;
        n  = 16'd13;
      end
      @(posedge clk); #1;
      go = 1'b0;
      lat++;
      if (ready) break;
      if (error !== pe || is_prime !== pp || res !== pr) moved = 1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", ready);
    end
    checks++;
    if ({error, is_prime, res} !== {1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL reset_outputs: got err=%b prime=%b res=%0d expected 0/0/0",
                         error, is_prime, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed(input logic [W-1:0] nv, input int exp_lat, input bit exp_e,
                            input bit exp_p, input logic [W-1:0] exp_r, input int spur);
    int lat;
    bit moved;
    issue(nv, spur, 1'b0, lat, moved);
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL latency n=%0d: got %0d expected %0d", nv, lat, exp_lat);
    end
    checks++;
    if ({error, is_prime, res} !== {exp_e, exp_p, exp_r}) begin
      errors++; $display("FAIL result n=%0d: got err=%b prime=%b res=%0d expected err=%b prime=%b res=%0d",
                         nv, error, is_prime, res, exp_e, exp_p, exp_r);
    end
    checks++;
    if (moved !== 1'b0) begin
      errors++; $display("FAIL outputs_stable n=%0d: got changed=1 expected 0", nv);
    end
  endtask

  task automatic test_done_edge();
    int lat;
    bit moved;
    issue(16'd2, 1, 1'b0, lat, moved);
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || res !== 16'd2) begin
      errors++; $display("FAIL done_edge_go: got ready=%b res=%0d expected ready=1 res=2", ready, res);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit moved;
    @(negedge clk);
    go = 1'b1;
    n  = 16'd65521;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_ready: got %b expected 1", ready);
    end
    checks++;
    if ({error, is_prime, res} !== {1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL reset_mid_outputs: got err=%b prime=%b res=%0d expected 0/0/0",
                         error, is_prime, res);
    end
    #1;
    rst_n = 1'b1;
    go    = 1'b1;
    n     = 16'd9;
    issue(16'd9, -1, 1'b1, lat, moved);
    checks++;
    if (lat !== 36) begin
      errors++; $display("FAIL after_reset_latency: got %0d expected 36", lat);
    end
    checks++;
    if ({error, is_prime, res} !== {1'b0, 1'b0, 16'd3}) begin
      errors++; $display("FAIL after_reset_n9: got err=%b prime=%b res=%0d expected 0/0/3",
                         error, is_prime, res);
    end
  endtask

  task automatic test_random(input int count, input int unsigned hi);
    int lat, k;
    bit moved, e, p;
    int unsigned r;
    logic [W-1:0] nv;
    for (int i = 0; i < count; i++) begin
      nv = W'($urandom_range(0, hi));
      model(nv, e, p, r, k);
      issue(nv, -1, 1'b0, lat, moved);
      checks++;
      if (lat !== 2 + k * (W + 1)) begin
        errors++; $display("FAIL rand_latency n=%0d: got %0d expected %0d", nv, lat, 2 + k * (W + 1));
      end
      checks++;
      if ({error, is_prime, res} !== {e, p, W'(r)}) begin
        errors++; $display("FAIL rand_result n=%0d: got err=%b prime=%b res=%0d expected err=%b prime=%b res=%0d",
                           nv, error, is_prime, res, e, p, r);
      end
      checks++;
      if (moved !== 1'b0) begin
        errors++; $display("FAIL rand_stable n=%0d: got changed=1 expected 0", nv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed(16'd2, 2, 1'b0, 1'b1, 16'd2, -1);
    test_fixed(16'd91, 70, 1'b0, 1'b0, 16'd7, -1);
    test_fixed(16'd3, 2, 1'b0, 1'b1, 16'd3, -1);
    test_fixed(16'd65521, 2 + 128 * 17, 1'b0, 1'b1, 16'd65521, -1);
    test_fixed(16'd65535, 2 + 2 * 17, 1'b0, 1'b0, 16'd3, -1);
    test_fixed(16'd0, 2, 1'b1, 1'b0, 16'd0, -1);
    test_fixed(16'd1, 2, 1'b1, 1'b0, 16'd0, -1);
    test_fixed(16'd4, 2 + 17, 1'b0, 1'b0, 16'd2, -1);
    test_fixed(16'd91, 70, 1'b0, 1'b0, 16'd7, 20);
    test_done_edge();
    test_reset_mid();
    test_random(12, 300);
    test_random(8, 65535);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
